// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter: controller
//   state encoding, PS/2 frame constants and the frame builder used when a
//   command byte is accepted.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Start + 8 data + parity + stop, then the device ACK on the 11th falling edge.
  localparam int FRAME_BITS = 11;
  localparam int ACK_EDGE   = 11;

  // Falling edge on which the stop bit goes out (line released).
  localparam logic [3:0] STOP_EDGE = 4'(FRAME_BITS - 1);
  localparam logic [3:0] ACK_EDGE_N = 4'(ACK_EDGE);

  // Payload shifted out LSB-first after the start bit: {odd parity, byte}.
  function automatic logic [8:0] build_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_edge_sync.sv
// ps2_host_tx_edge_sync
//   Brings the asynchronous PS/2 clock and data lines into the clk domain
//   and flags falling edges of the PS/2 clock. The same block serves the
//   scan-code receiver that shares these wires.
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   ps2_clk    raw PS/2 clock line
//   ps2_data   raw PS/2 data line
//   clk_sync   synchronized PS/2 clock level
//   data_sync  synchronized PS/2 data level (2 flops)
//   clk_fall   one-cycle pulse on a falling PS/2 clock edge
module ps2_host_tx_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Flops reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      // stage p0: metastability capture
      clk_p0  <= ps2_clk;
      data_p0 <= ps2_data;
      // stage p1: synchronized level
      clk_p1  <= clk_p0;
      data_p1 <= data_p0;
      // stage p2: delayed copy for edge detection
      clk_p2  <= clk_p1;
    end
  end

  assign clk_sync  = clk_p1;
  assign data_sync = data_p1;
  assign clk_fall  = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 command transmitter. Inhibits the bus, issues the
//   request-to-send, shifts one byte out LSB-first with odd parity on the
//   device-generated clock and checks the device ACK.
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   ps2_clk       raw PS/2 clock line (async)
//   ps2_data      raw PS/2 data line (async)
//   ps2_clk_oe    1 = pull ps2_clk low
//   ps2_data_oe   1 = pull ps2_data low
//   cmd_data      command byte, captured on accept
//   cmd_valid     send request; accepted when cmd_ready is high
//   cmd_ready     high only while idle
//   tx_busy       high while a transaction is in progress (receiver discards traffic)
//   done          one-cycle pulse at the end of a transaction
//   ack_ok        device acknowledged; valid from done until the next accept
//   timeout       transaction aborted; valid from done until the next accept
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tx_busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [8:0]       shreg;
  logic [3:0]       edge_cnt;
  logic [3:0]       edge_nxt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             clk_sync, data_sync, clk_fall;

  ps2_host_tx_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign edge_nxt = edge_cnt + 4'd1;

  // Data registers (shreg, counters) are initialised on entry to the state
  // that uses them, so only control state is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      cmd_ready   <= 1'b1;
      tx_busy     <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            shreg      <= build_frame(cmd_data);
            ack_ok     <= 1'b0;
            timeout    <= 1'b0;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
            cmd_ready  <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end

        // Device clock glitches are ignored until the shift phase.
        ST_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= ST_START;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end

        ST_START: begin
          ps2_clk_oe <= 1'b0;
          edge_cnt   <= '0;
          to_cnt     <= '0;
          state      <= ST_SHIFT;
        end

        ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (to_cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout     <= 1'b1;
            ack_ok      <= 1'b0;
            done        <= 1'b1;
            cmd_ready   <= 1'b1;
            tx_busy     <= 1'b0;
            state       <= ST_IDLE;
          end else if (state == ST_SHIFT) begin
            // Data only moves right after a fall, while the device holds clock low.
            if (clk_fall) begin
              edge_cnt <= edge_nxt;
              if (edge_nxt == STOP_EDGE) begin
                ps2_data_oe <= 1'b0;
                state       <= ST_ACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= shreg >> 1;
              end
            end
          end else if (state == ST_ACK) begin
            if (clk_fall && edge_nxt == ACK_EDGE_N) begin
              edge_cnt <= edge_nxt;
              ack_ok   <= ~data_sync;
              state    <= ST_WAIT_IDLE;
            end
          end else begin
            if (clk_sync && data_sync) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              tx_busy   <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          cmd_ready   <= 1'b1;
          tx_busy     <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// open-drain lines (clock period 200 clk: 100 low, 100 high).
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       dev_clk_low;
  logic       dev_data_low;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       cmd_ready, tx_busy, done, ack_ok, timeout;
  logic       ps2_clk_w, ps2_data_w;

  int total = 0;
  int bad = 0;
  int idle_seen = 0;

  always #5 clk = ~clk;

  // Wired-AND with pull-ups.
  assign ps2_clk_w  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_w = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(4000)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk_w),
    .ps2_data    (ps2_data_w),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .tx_busy     (tx_busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are looked at on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (tx_busy !== 1'b1) idle_seen++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Entered on the falling edge right after the accepting rising edge.
  task automatic run_after_accept();
    int n = 0;
    chk("accept_busy", 32'(tx_busy), 32'd1);
    chk("accept_ready", 32'(cmd_ready), 32'd0);
    chk("accept_clr_ack", 32'(ack_ok), 32'd0);
    chk("accept_clr_to", 32'(timeout), 32'd0);
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      n++;
      tick();
    end
    chk("inhibit_len", 32'(n), 32'd8);
    chk("start_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
    tick();
    chk("clk_release", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
  endtask

  task automatic start_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    idle_seen = 0;
    run_after_accept();
  endtask

  // Device clocks 10 bits, sampling data on each rising edge, then the
  // 11th clock with data pulled low (ACK) or left high.
  task automatic dev_frame(input bit give_ack, input logic [9:0] exp_bits, input string tag);
    logic [9:0] got;
    got = '0;
    ticks(50);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      ticks(100);
      dev_clk_low = 1'b0;
      got[i] = ps2_data_w;
      ticks(100);
    end
    if (give_ack) dev_data_low = 1'b1;
    ticks(50);
    dev_clk_low = 1'b1;
    ticks(100);
    dev_clk_low = 1'b0;
    if (give_ack) begin
      ticks(20);
      dev_data_low = 1'b0;
    end
    chk(tag, 32'(got), 32'(exp_bits));
  endtask

  task automatic finish_xfer(input bit exp_ack, input bit exp_to);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("ack_ok", 32'(ack_ok), 32'(exp_ack));
    chk("timeout", 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack", 32'(ack_ok), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    ticks(5);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    start_cmd(8'hED);
    dev_frame(1'b1, 10'b11_1110_1101, "frame_ED");
    finish_xfer(1'b1, 1'b0);

    // Parity: 0x00 -> 1, 0xFF -> 1, 0x01 -> 0
    start_cmd(8'h00);
    dev_frame(1'b1, 10'b11_0000_0000, "frame_00");
    finish_xfer(1'b1, 1'b0);
    start_cmd(8'hFF);
    dev_frame(1'b1, 10'b11_1111_1111, "frame_FF");
    finish_xfer(1'b1, 1'b0);
    start_cmd(8'h01);
    dev_frame(1'b1, 10'b10_0000_0001, "frame_01");
    finish_xfer(1'b1, 1'b0);

    // Device does not ACK
    start_cmd(8'h12);
    dev_frame(1'b0, 10'b11_0001_0010, "frame_12");
    finish_xfer(1'b0, 1'b0);

    // Device never clocks: done 4000 cycles after clock release
    start_cmd(8'h55);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd4000);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_ack", 32'(ack_ok), 32'd0);
    chk("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);

    // Reset after the 4th falling edge
    start_cmd(8'h34);
    ticks(50);
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1;
      ticks(100);
      dev_clk_low = 1'b0;
      ticks(100);
    end
    dev_clk_low = 1'b1;
    ticks(10);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    ticks(10);
    start_cmd(8'hF4);
    dev_frame(1'b1, 10'b10_1111_0100, "frame_F4");
    finish_xfer(1'b1, 1'b0);

    // cmd_valid held: 0xAA then 0x55, second accepted only after done
    @(negedge clk);
    cmd_data  = 8'hAA;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_data  = 8'h55;
    idle_seen = 0;
    run_after_accept();
    dev_frame(1'b1, 10'b11_1010_1010, "frame_AA");
    finish_xfer(1'b1, 1'b0);
    chk("busy_AA", 32'(idle_seen), 32'd1);
    chk("ready_at_done", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("accept_after_done", 32'(tx_busy), 32'd1);
    cmd_valid = 1'b0;
    idle_seen = 0;
    run_after_accept();
    dev_frame(1'b1, 10'b11_0101_0101, "frame_55");
    finish_xfer(1'b1, 1'b0);
    chk("busy_55", 32'(idle_seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
